// File: rtl/dft_pkg.sv
// Shared DFT definitions: TAP opcodes, 1149.1 state encodings, data-register select type.
package dft_pkg;

  localparam int unsigned EXTEST     = 0;
  localparam int unsigned SAMPLE     = 1;
  localparam int unsigned IDCODE_OP  = 2;
  localparam int unsigned BIST_OP    = 3;
  localparam int unsigned INTSCAN_OP = 4;

  localparam logic [3:0] TLR      = 4'hF;
  localparam logic [3:0] RTI      = 4'hC;
  localparam logic [3:0] SEL_DR   = 4'h7;
  localparam logic [3:0] CAP_DR   = 4'h6;
  localparam logic [3:0] SH_DR    = 4'h2;
  localparam logic [3:0] EX1_DR   = 4'h1;
  localparam logic [3:0] PAUSE_DR = 4'h3;
  localparam logic [3:0] EX2_DR   = 4'h0;
  localparam logic [3:0] UPD_DR   = 4'h5;
  localparam logic [3:0] SEL_IR   = 4'h4;
  localparam logic [3:0] CAP_IR   = 4'hE;
  localparam logic [3:0] SH_IR    = 4'hA;
  localparam logic [3:0] EX1_IR   = 4'h9;
  localparam logic [3:0] PAUSE_IR = 4'hB;
  localparam logic [3:0] EX2_IR   = 4'h8;
  localparam logic [3:0] UPD_IR   = 4'hD;

  typedef enum logic [2:0] {DR_BYPASS, DR_IDCODE, DR_BSR, DR_BIST, DR_IS} dr_sel_e;

  // BYPASS is the all-ones code for whatever IR width the instance uses
  function automatic int unsigned bypass_op(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/tap_fsm.sv
// 16-state 1149.1 TAP controller: next-state logic and state register.
module tap_fsm import dft_pkg::*; (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       tms,
  output logic [3:0] tap_state
);

  logic [3:0] nxt;

  always_comb begin
    nxt = TLR;
    case (tap_state)
      TLR:      nxt = tms ? TLR    : RTI;
      RTI:      nxt = tms ? SEL_DR : RTI;
      SEL_DR:   nxt = tms ? SEL_IR : CAP_DR;
      CAP_DR:   nxt = tms ? EX1_DR : SH_DR;
      SH_DR:    nxt = tms ? EX1_DR : SH_DR;
      EX1_DR:   nxt = tms ? UPD_DR : PAUSE_DR;
      PAUSE_DR: nxt = tms ? EX2_DR : PAUSE_DR;
      EX2_DR:   nxt = tms ? UPD_DR : SH_DR;
      UPD_DR:   nxt = tms ? SEL_DR : RTI;
      SEL_IR:   nxt = tms ? TLR    : CAP_IR;
      CAP_IR:   nxt = tms ? EX1_IR : SH_IR;
      SH_IR:    nxt = tms ? EX1_IR : SH_IR;
      EX1_IR:   nxt = tms ? UPD_IR : PAUSE_IR;
      PAUSE_IR: nxt = tms ? EX2_IR : PAUSE_IR;
      EX2_IR:   nxt = tms ? UPD_IR : SH_IR;
      UPD_IR:   nxt = tms ? SEL_DR : RTI;
      default:  nxt = TLR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) tap_state <= TLR;
    else        tap_state <= nxt;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller top: instruction/bypass/IDCODE registers, opcode decode, external chain strobes.
module jtag_tap_ctrl import dft_pkg::*; #(
  parameter int          IR_W   = 4,
  parameter logic [31:0] IDCODE = 32'h1076_5001
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic            tms,
  input  logic            tdi,
  output logic            tdo,
  output logic            tdo_en,
  input  logic            bsr_tdo,
  input  logic            bist_tdo,
  input  logic            is_tdo,
  output logic            bsr_sel,
  output logic            bist_sel,
  output logic            is_sel,
  output logic            capture_dr,
  output logic            shift_dr,
  output logic            update_dr,
  output logic [IR_W-1:0] instruction,
  output logic            test_mode,
  output logic            bist_en,
  output logic            is_en,
  output logic [3:0]      tap_state
);

  localparam logic [IR_W-1:0] BYPASS = IR_W'(bypass_op(IR_W));

  logic [3:0]      state;
  logic [IR_W-1:0] ir_sh, instr_q;
  logic            bypass_q;
  logic [31:0]     id_sh;
  dr_sel_e         dr_sel;
  logic            ext_sel;

  tap_fsm u_fsm (.clk(clk), .rst_l(rst_l), .tms(tms), .tap_state(state));

  assign tap_state = state;

  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) begin
      ir_sh    <= '0;
      instr_q  <= IR_W'(IDCODE_OP);
      bypass_q <= 1'b0;
      id_sh    <= IDCODE;
    end else begin
      case (state)
        TLR:    instr_q <= IR_W'(IDCODE_OP);
        CAP_IR: ir_sh   <= IR_W'(2'b01);
        SH_IR:  ir_sh   <= {tdi, ir_sh[IR_W-1:1]};
        UPD_IR: instr_q <= ir_sh;
        CAP_DR: begin
          bypass_q <= 1'b0;
          id_sh    <= IDCODE;
        end
        SH_DR: begin
          bypass_q <= tdi;
          id_sh    <= {tdi, id_sh[31:1]};
        end
        default: ;
      endcase
    end

  // TLR forces IDCODE at once so the reset instruction is visible on TLR entry
  assign instruction = (state == TLR) ? IR_W'(IDCODE_OP) : instr_q;

  always_comb begin
    dr_sel = DR_BYPASS;
    case (instruction)
      IR_W'(EXTEST),
      IR_W'(SAMPLE):     dr_sel = DR_BSR;
      IR_W'(IDCODE_OP):  dr_sel = DR_IDCODE;
      IR_W'(BIST_OP):    dr_sel = DR_BIST;
      IR_W'(INTSCAN_OP): dr_sel = DR_IS;
      BYPASS:            dr_sel = DR_BYPASS;
      default:           dr_sel = DR_BYPASS;
    endcase
  end

  assign bsr_sel   = (dr_sel == DR_BSR);
  assign bist_sel  = (dr_sel == DR_BIST);
  assign is_sel    = (dr_sel == DR_IS);
  assign ext_sel   = bsr_sel | bist_sel | is_sel;
  assign test_mode = (instruction == IR_W'(EXTEST)) || (instruction == IR_W'(INTSCAN_OP));
  assign bist_en   = bist_sel;
  assign is_en     = is_sel;

  assign capture_dr = (state == CAP_DR) && ext_sel;
  assign shift_dr   = (state == SH_DR)  && ext_sel;
  assign update_dr  = (state == UPD_DR) && ext_sel;

  assign tdo_en = (state == SH_IR) || (state == SH_DR);

  always_comb begin
    tdo = 1'b0;
    if (state == SH_IR) tdo = ir_sh[0];
    else if (state == SH_DR) begin
      case (dr_sel)
        DR_BSR:    tdo = bsr_tdo;
        DR_BIST:   tdo = bist_tdo;
        DR_IS:     tdo = is_tdo;
        DR_IDCODE: tdo = id_sh[0];
        default:   tdo = bypass_q;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Self-checking bench for jtag_tap_ctrl: scan-level reference model with randomized IR/DR traffic.
module tb_jtag_tap_ctrl;

  localparam int          IR_W = 4;
  localparam logic [31:0] ID   = 32'h1076_5001;
  // column encodings indexed Sel,Cap,Sh,Ex1,Pause,Ex2,Upd (index 0 = Sel)
  localparam logic [6:0][3:0] DR_ENC = {4'h5, 4'h0, 4'h3, 4'h1, 4'h2, 4'h6, 4'h7};
  localparam logic [6:0][3:0] IR_ENC = {4'hD, 4'h8, 4'hB, 4'h9, 4'hA, 4'hE, 4'h4};

  logic clk = 1'b0, rst_l = 1'b0, tms = 1'b1, tdi = 1'b0;
  logic bsr_tdo = 1'b0, bist_tdo = 1'b0, is_tdo = 1'b0;
  logic tdo, tdo_en, bsr_sel, bist_sel, is_sel, capture_dr, shift_dr, update_dr;
  logic test_mode, bist_en, is_en;
  logic [IR_W-1:0] instruction;
  logic [3:0] tap_state;

  int total = 0, bad = 0;
  int mcol, mpos;

  jtag_tap_ctrl #(.IR_W(IR_W), .IDCODE(ID)) dut (
    .clk(clk), .rst_l(rst_l), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
    .bsr_tdo(bsr_tdo), .bist_tdo(bist_tdo), .is_tdo(is_tdo),
    .bsr_sel(bsr_sel), .bist_sel(bist_sel), .is_sel(is_sel),
    .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
    .instruction(instruction), .test_mode(test_mode), .bist_en(bist_en), .is_en(is_en),
    .tap_state(tap_state)
  );

  always #5 clk = ~clk;

  task automatic step(input logic t, input logic d);
    tms = t; tdi = d;
    @(posedge clk); #1;
  endtask

  // Model: TLR/RTI as column 0, then the DR (1) and IR (2) columns share one shape
  function automatic logic [3:0] m_enc(input int col, input int pos);
    if (col == 0) return (pos == 0) ? 4'hF : 4'hC;
    if (col == 1) return DR_ENC[pos];
    return IR_ENC[pos];
  endfunction

  task automatic m_advance(input logic t);
    if (mcol == 0) begin
      if (mpos == 0) mpos = t ? 0 : 1;
      else if (t) begin mcol = 1; mpos = 0; end
    end else begin
      case (mpos)
        0: if (!t) mpos = 1;
           else if (mcol == 1) mcol = 2;
           else begin mcol = 0; mpos = 0; end
        1, 2: mpos = t ? 3 : 2;
        3: mpos = t ? 6 : 4;
        4: mpos = t ? 5 : 4;
        5: mpos = t ? 6 : 2;
        default: if (t) begin mcol = 1; mpos = 0; end else begin mcol = 0; mpos = 1; end
      endcase
    end
  endtask

  // 0 bsr, 1 bist, 2 is, 3 idcode, 4 bypass
  function automatic int chain_of(input logic [IR_W-1:0] c);
    case (c)
      4'd0, 4'd1: return 0;
      4'd3:       return 1;
      4'd4:       return 2;
      4'd2:       return 3;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [5:0] exp_decode(input logic [IR_W-1:0] c);
    logic b, bi, s, tm;
    b = (c <= 4'd1); bi = (c == 4'd3); s = (c == 4'd4); tm = (c == 4'd0) || (c == 4'd4);
    return {b, bi, s, tm, bi, s};
  endfunction

  function automatic logic [63:0] exp_dout(input logic [IR_W-1:0] c, input int n,
                                           input logic [63:0] din, input logic [63:0] ext);
    logic [63:0] e;
    e = '0;
    for (int i = 0; i < n; i++) begin
      case (chain_of(c))
        0, 1, 2: e[i] = ext[i];
        3:       e[i] = (i < 32) ? ID[i] : din[i-32];
        default: e[i] = (i == 0) ? 1'b0 : din[i-1];
      endcase
    end
    return e;
  endfunction

  // From RTI: shift code into IR; ends in Update-IR (instruction not yet changed)
  task automatic load_ir(input logic [IR_W-1:0] code, output logic [IR_W-1:0] cap);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < IR_W; i++) begin
      cap[i] = tdo;
      step(i == IR_W-1, code[i]);
    end
    step(1, 0);
  endtask

  // From RTI: capture, shift n bits, update, back to RTI
  task automatic shift_dr_seq(input int n, input logic [63:0] din, input int chain,
                              output logic [63:0] dout, output logic [63:0] ext,
                              output int ncap, output int nsh, output int nupd, output int nen);
    int steps;
    steps = n + 5;
    dout = '0; ext = '0; ncap = 0; nsh = 0; nupd = 0; nen = 0;
    for (int k = 0; k < steps; k++) begin
      logic t, d;
      int i;
      i = k - 3; d = 1'b0;
      if (k == 0) t = 1'b1;
      else if (k < 3) t = 1'b0;
      else if (i < n) t = (i == n-1);
      else t = (k == steps-2);
      if (i >= 0 && i < n) begin
        bsr_tdo = 1'($urandom_range(0, 1));
        bist_tdo = 1'($urandom_range(0, 1));
        is_tdo = 1'($urandom_range(0, 1));
        d = din[i];
      end
      #1;
      if (i >= 0 && i < n) begin
        dout[i] = tdo;
        ext[i] = (chain == 0) ? bsr_tdo : (chain == 1) ? bist_tdo : is_tdo;
      end
      if (capture_dr) ncap++;
      if (shift_dr) nsh++;
      if (update_dr) nupd++;
      if (tdo_en) nen++;
      step(t, d);
    end
  endtask

  task automatic test_reset;
    rst_l = 1'b0; tms = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (tap_state !== 4'hF) begin bad++; $display("FAIL reset_state: got %h want f", tap_state); end
    total++; if (instruction !== 4'd2) begin bad++; $display("FAIL reset_instr: got %h want 2", instruction); end
    total++;
    if ({tdo, tdo_en, bsr_sel, bist_sel, is_sel, capture_dr, shift_dr, update_dr, test_mode, bist_en, is_en} !== 11'b0) begin
      bad++; $display("FAIL reset_outputs: got %b want 0", {tdo, tdo_en, bsr_sel, bist_sel, is_sel,
                      capture_dr, shift_dr, update_dr, test_mode, bist_en, is_en});
    end
    rst_l = 1'b1;
    step(1, 0);
  endtask

  task automatic test_idcode_scan;
    logic [31:0] got, got2, din;
    int en;
    en = 0;
    step(0, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 32; i++) begin
      got[i] = tdo; if (tdo_en) en++;
      din[i] = 1'($urandom_range(0, 1));
      step(i == 31, din[i]);
    end
    total++; if (got !== ID) begin bad++; $display("FAIL idcode_scan: got %h want %h", got, ID); end
    total++; if (en != 32 || tdo_en !== 1'b0) begin bad++; $display("FAIL idcode_tdo_en: got %0d/%b want 32/0", en, tdo_en); end
    step(0, 0); step(1, 0); step(0, 0);
    for (int i = 0; i < 32; i++) begin
      got2[i] = tdo;
      step(i == 31, 1'b0);
    end
    total++; if (got2 !== din) begin bad++; $display("FAIL pause_hold: got %h want %h", got2, din); end
    step(1, 0); step(0, 0);
    total++; if (tap_state !== 4'hC) begin bad++; $display("FAIL back_to_rti: got %h want c", tap_state); end
  endtask

  task automatic test_bypass;
    logic [IR_W-1:0] cap;
    logic [63:0] dout, ext;
    int nc, ns, nu, ne;
    load_ir(4'hF, cap); step(0, 0);
    total++; if (instruction !== 4'hF) begin bad++; $display("FAIL bypass_instr: got %h want f", instruction); end
    shift_dr_seq(4, 64'b1101, 4, dout, ext, nc, ns, nu, ne);
    total++; if (dout[3:0] !== 4'b1010) begin bad++; $display("FAIL bypass_data: got %b want 1010", dout[3:0]); end
    total++;
    if ({bsr_sel, bist_sel, is_sel} !== 3'b0 || nc != 0 || ns != 0 || nu != 0) begin
      bad++; $display("FAIL bypass_strobes: sel=%b cap=%0d sh=%0d upd=%0d want all 0", {bsr_sel, bist_sel, is_sel}, nc, ns, nu);
    end
  endtask

  task automatic test_extest;
    logic [IR_W-1:0] cap;
    logic [63:0] dout, ext, din;
    int nc, ns, nu, ne;
    load_ir(4'h0, cap); step(0, 0);
    total++; if ({bsr_sel, bist_sel, is_sel, test_mode} !== 4'b1001) begin
      bad++; $display("FAIL extest_decode: got %b want 1001", {bsr_sel, bist_sel, is_sel, test_mode}); end
    din = {$urandom, $urandom};
    shift_dr_seq(8, din, 0, dout, ext, nc, ns, nu, ne);
    total++; if (nc != 1 || ns != 8 || nu != 1 || ne != 8) begin
      bad++; $display("FAIL extest_strobes: got %0d/%0d/%0d/%0d want 1/8/1/8", nc, ns, nu, ne); end
    total++; if (dout[7:0] !== ext[7:0]) begin bad++; $display("FAIL extest_tdo: got %h want %h", dout[7:0], ext[7:0]); end
  endtask

  task automatic test_ir_capture_illegal;
    logic [IR_W-1:0] cap;
    logic [63:0] dout, ext, din;
    int nc, ns, nu, ne;
    load_ir(4'h9, cap); step(0, 0);
    total++; if (cap !== 4'b0001) begin bad++; $display("FAIL ir_capture: got %b want 0001", cap); end
    total++; if (instruction !== 4'h9) begin bad++; $display("FAIL illegal_instr: got %h want 9", instruction); end
    din = {$urandom, $urandom};
    shift_dr_seq(6, din, 4, dout, ext, nc, ns, nu, ne);
    total++;
    if (dout !== exp_dout(4'h9, 6, din, ext) || {bsr_sel, bist_sel, is_sel, test_mode} !== 4'b0 || nc + ns + nu != 0) begin
      bad++; $display("FAIL illegal_as_bypass: got %h want %h", dout, exp_dout(4'h9, 6, din, ext));
    end
  endtask

  task automatic test_bist_intscan;
    logic [IR_W-1:0] cap, old;
    old = instruction;
    load_ir(4'h3, cap);
    total++; if (instruction !== old || bist_en !== 1'b0) begin
      bad++; $display("FAIL bist_early: got %h/%b want %h/0", instruction, bist_en, old); end
    step(0, 0);
    total++; if (instruction !== 4'h3 || {bist_en, is_en, test_mode} !== 3'b100) begin
      bad++; $display("FAIL bist_on: got %h/%b want 3/100", instruction, {bist_en, is_en, test_mode}); end
    load_ir(4'h4, cap);
    total++; if ({bist_en, is_en} !== 2'b10) begin bad++; $display("FAIL is_early: got %b want 10", {bist_en, is_en}); end
    step(0, 0);
    total++; if (instruction !== 4'h4 || {bist_en, is_en, test_mode} !== 3'b011) begin
      bad++; $display("FAIL is_on: got %h/%b want 4/011", instruction, {bist_en, is_en, test_mode}); end
  endtask

  task automatic test_random;
    logic [IR_W-1:0] cap, code;
    logic [63:0] dout, ext, din;
    int nc, ns, nu, ne, n, ch;
    repeat (12) begin
      code = IR_W'($urandom_range(0, 15));
      load_ir(code, cap); step(0, 0);
      total++; if (instruction !== code || cap !== 4'b0001) begin
        bad++; $display("FAIL rnd_ir: got %h cap %b want %h cap 0001", instruction, cap, code); end
      total++; if ({bsr_sel, bist_sel, is_sel, test_mode, bist_en, is_en} !== exp_decode(code)) begin
        bad++; $display("FAIL rnd_decode: code %h got %b want %b", code,
                        {bsr_sel, bist_sel, is_sel, test_mode, bist_en, is_en}, exp_decode(code)); end
      n = $urandom_range(1, 64);
      din = {$urandom, $urandom};
      ch = chain_of(code);
      shift_dr_seq(n, din, ch, dout, ext, nc, ns, nu, ne);
      total++; if (dout !== exp_dout(code, n, din, ext)) begin
        bad++; $display("FAIL rnd_dr: code %h n %0d got %h want %h", code, n, dout, exp_dout(code, n, din, ext)); end
      total++;
      if (ch < 3 ? (nc != 1 || ns != n || nu != 1) : (nc + ns + nu != 0)) begin
        bad++; $display("FAIL rnd_strobes: code %h got %0d/%0d/%0d n %0d", code, nc, ns, nu, n);
      end
      total++; if (ne != n) begin bad++; $display("FAIL rnd_tdo_en: got %0d want %0d", ne, n); end
    end
  endtask

  task automatic test_tlr_from_any;
    logic t;
    mcol = 0; mpos = 1;
    repeat (6) begin
      repeat ($urandom_range(3, 30)) begin
        t = 1'($urandom_range(0, 1));
        step(t, 1'($urandom_range(0, 1)));
        m_advance(t);
        total++; if (tap_state !== m_enc(mcol, mpos)) begin
          bad++; $display("FAIL walk_state: got %h want %h", tap_state, m_enc(mcol, mpos)); end
      end
      repeat (5) begin step(1, 0); m_advance(1'b1); end
      total++; if (tap_state !== 4'hF || instruction !== 4'd2) begin
        bad++; $display("FAIL five_ones: got %h/%h want f/2", tap_state, instruction); end
    end
    step(0, 0);
  endtask

  task automatic test_midshift_reset;
    logic [IR_W-1:0] cap;
    load_ir(4'h4, cap); step(0, 0);
    step(1, 0); step(0, 0); step(0, 0);
    repeat (3) step(0, 1);
    #2 rst_l = 1'b0;
    #1;
    total++; if (tap_state !== 4'hF || instruction !== 4'd2) begin
      bad++; $display("FAIL midreset_state: got %h/%h want f/2", tap_state, instruction); end
    total++;
    if ({tdo, tdo_en, is_sel, shift_dr, test_mode, is_en} !== 6'b0) begin
      bad++; $display("FAIL midreset_outputs: got %b want 0", {tdo, tdo_en, is_sel, shift_dr, test_mode, is_en});
    end
    #1 rst_l = 1'b1;
    step(0, 0);
    total++; if (instruction !== 4'd2 || tap_state !== 4'hC) begin
      bad++; $display("FAIL after_reset: got %h/%h want 2/c", instruction, tap_state); end
  endtask

  initial begin
    test_reset;
    test_idcode_scan;
    test_bypass;
    test_extest;
    test_ir_capture_illegal;
    test_bist_intscan;
    test_random;
    test_tlr_from_any;
    test_midshift_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jtag_tap_ctrl.md
# jtag_tap_ctrl

Parametrised IEEE 1149.1-style test access port controller for the P5 DFT wrapper. It runs the full 16-state TAP state machine and owns a configurable-width instruction register, the bypass register and the IDCODE register. It also generates per-chain select and capture/shift/update strobes for the external boundary-scan, BIST and internal-scan data registers. It replaces the 2-bit instruction register and decode: same role, generalised width, plus full TAP sequencing, IDCODE and illegal-opcode handling.

## Interface
- IR_W, 4: instruction register width; minimum 3.
- IDCODE, 32'h1076_5001: device ID; bit 0 must be 1.
- clk  in  1  test clock (TCK); all state changes on its rising edge.
- rst_l  in  1  asynchronous, active-low reset (TRST).
- tms  in  1  test mode select, sampled on the rising edge of clk.
- tdi  in  1  test data in.
- tdo  out  1  test data out.
- tdo_en  out  1  high only in Shift-IR and Shift-DR.
- bsr_tdo, bist_tdo, is_tdo  in  1 each  serial outputs of the external chains.
- bsr_sel, bist_sel, is_sel  out  1 each  one-hot external data-register select; all 0 for the internal registers.
- capture_dr, shift_dr, update_dr  out  1 each  single-cycle-qualified strobes for external chains.
- instruction  out  IR_W  current active instruction.
- test_mode  out  1  drives boundary-cell testNorm; high for EXTEST and INTSCAN.
- bist_en  out  1  high while instruction is BIST.
- is_en  out  1  high while instruction is INTSCAN.
- tap_state  out  4  current state encoding, for debug.

## Operation
- Opcodes:
  - EXTEST = 0, selects BSR.
  - SAMPLE = 1, selects BSR with test_mode 0.
  - IDCODE = 2, selects the internal 32-bit ID register.
  - BIST = 3, selects the BIST chain.
  - INTSCAN = 4, selects the IS chain.
  - BYPASS = all ones.
  - Every other code decodes exactly as BYPASS, and instruction still reports the raw code.
- States and encoding (hex): TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauseDR 3, Ex2DR 0, UpdDR 5, SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauseIR B, Ex2IR 8, UpdIR D.
- Transitions are standard 1149.1 on tms. Five consecutive tms=1 edges reach TLR from any state.
- TLR:
  - instruction := IDCODE; all strobes 0.
  - Selects are still decoded from instruction.
- IR path, using an IR_W-bit shift register ir_sh:
  - CapIR loads {0…,2'b01}.
  - ShIR shifts right with tdi into the MSB; tdo = ir_sh[0].
  - UpdIR copies ir_sh into instruction on that edge, so the new value is visible the following cycle.
- Bypass register: 1 bit; cleared in CapDR; takes tdi in ShDR; tdo = bypass.
- ID register:
  - CapDR loads IDCODE.
  - ShDR shifts right with tdi into bit 31; tdo = id_sh[0].
- External chains:
  - capture_dr / shift_dr / update_dr = (state==CapDR / ShDR / UpdDR) AND any external select high.
  - The chain acts on the same edge; tdo = the selected *_tdo.
- tdo:
  - Combinational mux from registered sources: ir_sh[0] in ShIR, the selected DR in ShDR, 0 otherwise.
- Pause and Exit states hold every shift register unchanged.

## Timing
- Reset values, asynchronous on rst_l low:
  - state TLR (tap_state F); instruction = IDCODE (2).
  - ir_sh = 0; bypass = 0; id_sh = IDCODE.
  - tdo 0; tdo_en 0; all strobes 0; bsr/bist/is_sel 0; test_mode 0; bist_en 0; is_en 0.
- Reset in mid-shift abandons the shift; instruction does not change until a later UpdIR.
- Latency:
  - instruction changes one cycle after the UpdIR edge.
  - The decode outputs are combinational from instruction, so they follow in the same cycle.
- Each shift edge in ShDR/ShIR moves exactly one bit. Scanning N bits requires N edges in the Shift state, the last with tms=1 (exit).
- Strobes are combinational from the state register and are glitch-free relative to clk.

## Structure
- Shared package dft_pkg holds:
  - opcode constants (EXTEST, SAMPLE, IDCODE_OP, BIST_OP, INTSCAN_OP);
  - the 4-bit TAP state encodings;
  - a BYPASS constant derived from IR_W.
- One natural sub-module, tap_fsm: the 16-state next-state logic plus state register, exporting tap_state. Registers and decode remain in the top module.

## Test plan
- Hold rst_l=0, then release. Scan the DR from reset (tms 0,1,0,0, then 32 ShDR cycles) → tdo shifts out 32'h1076_5001 LSB first; tdo_en high for exactly 32 cycles.
- From any state, drive tms=1 for 5 edges → tap_state = F and instruction = 2. Also test from ShDR with a mid-shift rst_l pulse → immediate TLR with all outputs at reset values.
- Load IR 4'hF, then shift DR with tdi pattern 1,0,1,1 → tdo = 0,1,0,1 (one-bit delay through bypass); all *_sel 0; no strobes.
- Load IR 0 (EXTEST) → bsr_sel=1 and test_mode=1. Capture/shift 8/update the DR → capture_dr pulses 1 cycle, shift_dr high 8 cycles, update_dr pulses 1 cycle, and tdo mirrors bsr_tdo.
- Capture the IR → first two tdo bits 1,0. Load illegal code 4'h9 → instruction reads 9 and behaves as BYPASS.
- Load IR 3, then 4 → bist_en=1 then is_en=1 with test_mode=1; each changes exactly one cycle after the UpdIR edge.
